// File: rtl/piu_pchinfo_scanner_pkg.sv
// Shared definitions for the PIU patch-info scanner: field widths, patch-type
// and boundary-location codes, scanner state encoding and a field extractor.
package piu_pchinfo_scanner_pkg;

  localparam int PIU_NUM_PCH    = 18;
  localparam int PIU_PCHADDR_BW = 5;
  localparam int PIU_PCHTYPE_BW = 4;
  localparam int PIU_BDLOC_BW   = 3;
  localparam int PIU_PCHSTAT_BW = PIU_PCHTYPE_BW + 2 * PIU_BDLOC_BW;

  // Patch-type codes (bit position in the start type mask).
  localparam logic [PIU_PCHTYPE_BW-1:0] PCHTYPE_ZT = 4'd0;
  localparam logic [PIU_PCHTYPE_BW-1:0] PCHTYPE_ZB = 4'd1;
  localparam logic [PIU_PCHTYPE_BW-1:0] PCHTYPE_M  = 4'd2;
  localparam logic [PIU_PCHTYPE_BW-1:0] PCHTYPE_AW = 4'd3;
  localparam logic [PIU_PCHTYPE_BW-1:0] PCHTYPE_AC = 4'd4;
  localparam logic [PIU_PCHTYPE_BW-1:0] PCHTYPE_AE = 4'd5;
  localparam logic [PIU_PCHTYPE_BW-1:0] PCHTYPE_X  = 4'd6;
  localparam logic [PIU_PCHTYPE_BW-1:0] PCHTYPE_L  = 4'd7;

  // Boundary-location codes.
  localparam logic [PIU_BDLOC_BW-1:0] BDLOC_I = 3'd0;
  localparam logic [PIU_BDLOC_BW-1:0] BDLOC_E = 3'd1;
  localparam logic [PIU_BDLOC_BW-1:0] BDLOC_W = 3'd2;
  localparam logic [PIU_BDLOC_BW-1:0] BDLOC_S = 3'd3;
  localparam logic [PIU_BDLOC_BW-1:0] BDLOC_N = 3'd4;

  // Scanner state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  // Extract the patch-type field (MSBs) of a ROM word.
  function automatic logic [PIU_PCHTYPE_BW-1:0] pchinfo_type(input logic [PIU_PCHSTAT_BW-1:0] info);
    return info[PIU_PCHSTAT_BW-1 -: PIU_PCHTYPE_BW];
  endfunction

endpackage

// File: rtl/piu_pchinfo_scanner.sv
// PIU static patch-info ROM sequencer. Walks every patch index once per start
// command and streams the entries whose type is selected by the mask through a
// one-entry valid/ready output slot.
// Optional feature macro: PIU_SCAN_ABORT_EN adds the scan_abort input.
module piu_pchinfo_scanner
  import piu_pchinfo_scanner_pkg::*;
#(
  parameter int  NUM_PCH    = PIU_NUM_PCH,
  parameter int  PCHADDR_BW = PIU_PCHADDR_BW,
  parameter int  PCHTYPE_BW = PIU_PCHTYPE_BW,
  parameter int  BDLOC_BW   = PIU_BDLOC_BW,
  localparam int PCHSTAT_BW = PCHTYPE_BW + 2 * BDLOC_BW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [2**PCHTYPE_BW-1:0] start_typemask,
  output logic [PCHADDR_BW-1:0]    rom_pchidx,
  input  logic [PCHSTAT_BW-1:0]    rom_pchinfo,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PCHADDR_BW-1:0]    out_pchidx,
  output logic [PCHSTAT_BW-1:0]    out_pchinfo,
`ifdef PIU_SCAN_ABORT_EN
  input  logic                     scan_abort,
`endif
  output logic                     scan_done,
  output logic [PCHADDR_BW:0]      match_cnt
);

  localparam int CNT_BW = PCHADDR_BW + 1;
  localparam logic [PCHADDR_BW-1:0] LAST_IDX = PCHADDR_BW'(NUM_PCH - 1);

  scan_state_e               state_r, state_nxt_s;
  logic [PCHADDR_BW-1:0]     cur_idx_r, cur_idx_nxt_s;
  logic [2**PCHTYPE_BW-1:0]  mask_r, mask_nxt_s;
  logic                      out_valid_r, out_valid_nxt_s;
  logic [PCHADDR_BW-1:0]     out_pchidx_r;
  logic [PCHSTAT_BW-1:0]     out_pchinfo_r;
  logic                      done_r;
  logic [CNT_BW-1:0]         match_cnt_r, match_cnt_nxt_s;
  logic                      load_s;
  logic                      match_s;
  logic                      slot_free_s;
  logic                      advance_s;
  logic                      abort_s;

`ifdef PIU_SCAN_ABORT_EN
  assign abort_s = scan_abort;
`else
  assign abort_s = 1'b0;
`endif

  assign match_s     = mask_r[rom_pchinfo[PCHSTAT_BW-1 -: PCHTYPE_BW]];
  assign slot_free_s = !out_valid_r || out_ready;
  assign advance_s   = !match_s || slot_free_s;

  assign start_ready = (state_r == ST_IDLE);
  assign rom_pchidx  = (state_r == ST_SCAN) ? cur_idx_r : {PCHADDR_BW{1'b0}};
  assign out_valid   = out_valid_r;
  assign out_pchidx  = out_pchidx_r;
  assign out_pchinfo = out_pchinfo_r;
  assign scan_done   = done_r;
  assign match_cnt   = match_cnt_r;

  // Next-state and slot control: a stalled match holds the index so the ROM is re-read.
  always_comb begin
    state_nxt_s     = state_r;
    cur_idx_nxt_s   = cur_idx_r;
    mask_nxt_s      = mask_r;
    out_valid_nxt_s = out_valid_r && !out_ready;
    match_cnt_nxt_s = match_cnt_r;
    load_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_valid) begin
          mask_nxt_s      = start_typemask;
          cur_idx_nxt_s   = {PCHADDR_BW{1'b0}};
          match_cnt_nxt_s = {CNT_BW{1'b0}};
          state_nxt_s     = ST_SCAN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (abort_s) begin
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_DONE;
        end else if (advance_s) begin
          if (match_s) begin
            load_s          = 1'b1;
            out_valid_nxt_s = 1'b1;
            match_cnt_nxt_s = match_cnt_r + CNT_BW'(1);
          end else begin
            load_s = 1'b0;
          end
          if (cur_idx_r == LAST_IDX) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            cur_idx_nxt_s = cur_idx_r + PCHADDR_BW'(1);
          end
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        if (abort_s) begin
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_DONE;
        end else if (!out_valid_r || out_ready) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, index, mask and counter registers; done pulse tracks entry into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cur_idx_r   <= {PCHADDR_BW{1'b0}};
      mask_r      <= {(2**PCHTYPE_BW){1'b0}};
      out_valid_r <= 1'b0;
      match_cnt_r <= {CNT_BW{1'b0}};
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cur_idx_r   <= cur_idx_nxt_s;
      mask_r      <= mask_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      match_cnt_r <= match_cnt_nxt_s;
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  // One-entry output slot: loaded with the matching index and ROM word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pchidx_r  <= {PCHADDR_BW{1'b0}};
      out_pchinfo_r <= {PCHSTAT_BW{1'b0}};
    end else if (load_s) begin
      out_pchidx_r  <= cur_idx_r;
      out_pchinfo_r <= rom_pchinfo;
    end else begin
      out_pchidx_r  <= out_pchidx_r;
      out_pchinfo_r <= out_pchinfo_r;
    end
  end

endmodule

// File: tb/tb_piu_pchinfo_scanner.sv
// Self-checking bench for piu_pchinfo_scanner with an 18-entry static ROM
// (3 rows of 6 patch columns) and a queue-based expected-beat model.
module tb_piu_pchinfo_scanner;
  import piu_pchinfo_scanner_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] start_typemask = 16'd0;
  logic [4:0]  rom_pchidx;
  logic [9:0]  rom_pchinfo;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_pchidx;
  logic [9:0]  out_pchinfo;
  logic        scan_done;
  logic [5:0]  match_cnt;
`ifdef PIU_SCAN_ABORT_EN
  logic        scan_abort = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piu_pchinfo_scanner dut (
    .clk            (clk),
    .rst            (rst),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .start_typemask (start_typemask),
    .rom_pchidx     (rom_pchidx),
    .rom_pchinfo    (rom_pchinfo),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pchidx     (out_pchidx),
    .out_pchinfo    (out_pchinfo),
`ifdef PIU_SCAN_ABORT_EN
    .scan_abort     (scan_abort),
`endif
    .scan_done      (scan_done),
    .match_cnt      (match_cnt)
  );

  // Static patch-info ROM contents.
  function automatic logic [9:0] rom_word(input int i);
    case (i)
      0:  return {PCHTYPE_ZT, BDLOC_I, BDLOC_E};
      1:  return {PCHTYPE_ZB, BDLOC_I, BDLOC_I};
      2:  return {PCHTYPE_M,  BDLOC_S, BDLOC_W};
      3:  return {PCHTYPE_M,  BDLOC_S, BDLOC_I};
      4:  return {PCHTYPE_M,  BDLOC_S, BDLOC_E};
      5:  return {PCHTYPE_ZB, BDLOC_I, BDLOC_E};
      6:  return {PCHTYPE_L,  BDLOC_I, BDLOC_W};
      7:  return {PCHTYPE_L,  BDLOC_I, BDLOC_I};
      8:  return {PCHTYPE_AW, BDLOC_I, BDLOC_W};
      9:  return {PCHTYPE_AC, BDLOC_I, BDLOC_I};
      10: return {PCHTYPE_AE, BDLOC_I, BDLOC_E};
      11: return {PCHTYPE_X,  BDLOC_I, BDLOC_I};
      12: return {PCHTYPE_L,  BDLOC_N, BDLOC_W};
      13: return {PCHTYPE_ZB, BDLOC_N, BDLOC_W};
      14: return {PCHTYPE_M,  BDLOC_N, BDLOC_W};
      15: return {PCHTYPE_M,  BDLOC_N, BDLOC_I};
      16: return {PCHTYPE_M,  BDLOC_N, BDLOC_E};
      17: return {PCHTYPE_L,  BDLOC_N, BDLOC_E};
      default: return 10'd0;
    endcase
  endfunction

  assign rom_pchinfo = rom_word(int'(rom_pchidx));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one scan and scores every transferred beat against the model queue.
  task automatic run_scan(input logic [15:0] m, input bit rand_ready, input bit check_timing,
                          input int busy_n, input int abort_after);
    logic [14:0] exp_q[$];
    logic [14:0] prev_beat;
    bit          prev_stall;
    int          exp_total, exp_cnt, done_n, first_n, first_idx, beats, abort_n;
    exp_q = {};
    first_idx = -1;
    for (int i = 0; i < 18; i++) begin
      if (m[pchinfo_type(rom_word(i))]) begin
        exp_q.push_back({5'(i), rom_word(i)});
        if (first_idx < 0) first_idx = i;
      end
    end
    exp_total = exp_q.size();
    exp_cnt   = (abort_after >= 0) ? abort_after : exp_total;
    @(negedge clk);
    check("start_ready_idle", start_ready, 1);
    start_valid    = 1'b1;
    start_typemask = m;
    @(posedge clk);
    done_n = -1; first_n = -1; beats = 0; prev_stall = 1'b0; prev_beat = 15'd0; abort_n = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      start_valid    = (n == busy_n);
      start_typemask = (n == busy_n) ? ~m : m;
      if (n == busy_n) check("start_ready_busy", start_ready, 0);
`ifdef PIU_SCAN_ABORT_EN
      scan_abort = 1'b0;
`endif
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_stable", {out_pchidx, out_pchinfo}, prev_beat);
      end
      if (out_valid && first_n < 0) first_n = n;
      if (scan_done) begin
        done_n = n;
        break;
      end
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() > 0) check("beat_data", {out_pchidx, out_pchinfo}, exp_q.pop_front());
`ifdef PIU_SCAN_ABORT_EN
        if (beats == abort_after) begin
          scan_abort = 1'b1;
          abort_n    = n;
        end
`endif
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_pchidx, out_pchinfo};
    end
    start_valid = 1'b0;
`ifdef PIU_SCAN_ABORT_EN
    scan_abort = 1'b0;
`endif
    check("scan_done_seen", done_n >= 0, 1);
    check("beat_count", beats, exp_cnt);
    check("match_cnt_done", match_cnt, exp_cnt);
    check("out_valid_at_done", out_valid, 0);
    if (exp_total == 0) check("never_valid", first_n, -1);
    if (check_timing) begin
      check("done_cycle", done_n, 19);
      if (first_idx >= 0) check("first_beat_cycle", first_n, first_idx + 1);
    end
    if (abort_after >= 0) check("abort_done_next", done_n, abort_n + 1);
    @(negedge clk);
    check("done_one_cycle", scan_done, 0);
    check("idle_after_done", start_ready, 1);
    check("match_cnt_hold", match_cnt, exp_cnt);
  endtask

  initial begin
    logic [15:0] m;
    bit          seen3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_start_ready", start_ready, 1);
    check("rst_match_cnt", match_cnt, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_rom_pchidx", rom_pchidx, 0);
    check("rst_out_data", {out_pchidx, out_pchinfo}, 0);

    // ZT only, always ready
    m = 16'd1 << PCHTYPE_ZT;
    run_scan(m, 1'b0, 1'b1, -1, -1);
    // M, always ready
    m = 16'd1 << PCHTYPE_M;
    run_scan(m, 1'b0, 1'b1, -1, -1);
    // AW|AC|AE|X with random backpressure
    m = (16'd1 << PCHTYPE_AW) | (16'd1 << PCHTYPE_AC) | (16'd1 << PCHTYPE_AE) | (16'd1 << PCHTYPE_X);
    run_scan(m, 1'b1, 1'b0, -1, -1);
    // empty mask, with an ignored start while busy
    run_scan(16'd0, 1'b0, 1'b1, 5, -1);
    // random masks with random backpressure
    for (int k = 0; k < 4; k++) begin
      m = 16'($urandom());
      run_scan(m, 1'b1, 1'b0, -1, -1);
    end
    // random mask with constant ready keeps the fixed scan length
    m = 16'($urandom());
    run_scan(m, 1'b0, 1'b1, -1, -1);

    // reset while the pchidx-3 beat is stalled
    @(negedge clk);
    start_valid    = 1'b1;
    start_typemask = 16'd1 << PCHTYPE_M;
    @(posedge clk);
    seen3 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      start_valid = 1'b0;
      if (out_valid && out_pchidx == 5'd3) begin
        out_ready = 1'b0;
        seen3     = 1'b1;
        break;
      end
      out_ready = 1'b1;
    end
    check("hold_beat3_seen", seen3, 1);
    @(negedge clk);
    check("hold_beat3_valid", out_valid, 1);
    check("hold_beat3_idx", out_pchidx, 3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", {out_pchidx, out_pchinfo}, 0);
    check("midrst_scan_done", scan_done, 0);
    check("midrst_match_cnt", match_cnt, 0);
    check("midrst_start_ready", start_ready, 1);
    check("midrst_rom_pchidx", rom_pchidx, 0);
    rst = 1'b0;

`ifdef PIU_SCAN_ABORT_EN
    // abort an M scan after two beats
    run_scan(16'd1 << PCHTYPE_M, 1'b0, 1'b0, -1, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/piu_pchinfo_scanner.md
Name: piu_pchinfo_scanner

Overview:
- Sequencer for the PIU static patch-info ROM.
- On a start command carrying a patch-type mask, walks every patch index 0..NUM_PCH-1 through the ROM read port and streams each matching entry (index plus static info) downstream over a valid/ready handshake.
- Sits between the PIU instruction front-end and the per-patch dynamic-info / measurement setup logic.
- Is the sole driver of the ROM index.

Parameters:
- NUM_PCH, 18, number of patches (ROM depth).
- PCHADDR_BW, 5, patch index width; must satisfy 2**PCHADDR_BW >= NUM_PCH.
- PCHTYPE_BW, 4, patch-type field width.
- BDLOC_BW, 3, boundary-location field width.
- PCHSTAT_BW, PCHTYPE_BW+2*BDLOC_BW, ROM word width; layout is {pchtype, z_bd, x_bd}, pchtype in the MSBs.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start_valid  in  1  scan request.
- start_ready  out  1  high only in IDLE.
- start_typemask  in  2**PCHTYPE_BW  bit t set selects pchtype code t.
- rom_pchidx  out  PCHADDR_BW  ROM read index; ROM data is combinational, same cycle.
- rom_pchinfo  in  PCHSTAT_BW  ROM read data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_pchidx  out  PCHADDR_BW  index of the matching patch.
- out_pchinfo  out  PCHSTAT_BW  static info of the matching patch.
- scan_done  out  1  one-cycle pulse when the scan completes.
- match_cnt  out  PCHADDR_BW+1  beats emitted in the current/last scan.

Behaviour:
- Reset values: state=IDLE, cur_idx=0, mask=0, out_valid=0, out_pchidx=0, out_pchinfo=0, scan_done=0, match_cnt=0. rst overrides everything, mid-scan included; the in-flight beat is dropped.
- rom_pchidx = cur_idx in SCAN, 0 otherwise.
- match = mask[rom_pchinfo[PCHSTAT_BW-1 -: PCHTYPE_BW]].
- IDLE:
  - start_ready=1.
  - On start_valid: latch mask, cur_idx=0, match_cnt=0, go to SCAN.
- SCAN:
  - slot_free = !out_valid | out_ready.
  - Advance when !match, or when match & slot_free. On match & slot_free, load the output register with {cur_idx, rom_pchinfo}, set out_valid=1, and increment match_cnt.
  - When match & !slot_free, hold cur_idx; the ROM is re-read next cycle.
  - If advancing at cur_idx==NUM_PCH-1, go to DRAIN; otherwise cur_idx+1. No wrap.
  - Non-matching indices cost 1 cycle each.
  - Latency: start accepted at cycle T gives a first-match beat at index 0 with out_valid high at T+2.
- Output handshake:
  - A beat transfers when out_valid & out_ready.
  - out_valid clears on transfer unless it is reloaded in the same cycle; back-to-back beats run at 1/cycle under constant out_ready.
  - Output data is stable while out_valid & !out_ready.
- DRAIN:
  - Wait until out_valid==0, or until out_valid & out_ready (output transfers that cycle).
  - Then go to DONE.
- DONE:
  - scan_done=1 for exactly one cycle, then return to IDLE.
  - match_cnt holds until the next start.
- mask==0: all indices are skipped; scan_done asserts at T+NUM_PCH+2 with match_cnt=0.
- start_valid outside IDLE is ignored (start_ready=0).

Optional Feature:
- Macro PIU_SCAN_ABORT_EN.
- When defined:
  - Adds input scan_abort (1 bit).
  - scan_abort in SCAN or DRAIN clears out_valid (discarding any un-accepted beat) and moves to DONE.
  - scan_done pulses next cycle; match_cnt keeps its value.
  - scan_abort in IDLE/DONE has no effect.
- When undefined: no port; scans always run to completion.

Decomposition:
- Shared package / define.v entries:
  - PCHTYPE_* codes, BDLOC_* codes, field widths.
  - Scanner state encoding (IDLE=0, SCAN=1, DRAIN=2, DONE=3).
  - A PCHINFO_TYPE field-extract macro.
- Single module; no sub-module is warranted. The output register is a one-entry slot inside the module.

Test Plan (bench instantiates the static ROM with NUM_PCHCOL=6, NUM_PCH=18):
- Mask = only PCHTYPE_ZT, out_ready=1 -> one beat, pchidx 0, pchinfo {ZT, BDLOC_I, BDLOC_E}; scan_done at T+20; match_cnt=1.
- Mask = PCHTYPE_M, out_ready=1 -> beats at pchidx 2,3,4 (z_bd=BDLOC_S) then 14,15,16 (z_bd=BDLOC_N); match_cnt=6.
- Mask = AW|AC|AE|X, out_ready toggled randomly -> pchidx 8,9,10,11 in order, no drops or duplicates, data stable while stalled.
- Mask = 0 -> no out_valid; scan_done at T+20; match_cnt=0. A second start while busy is ignored.
- rst asserted while holding the pchidx-3 beat with out_ready=0 -> next cycle all outputs at reset values, state IDLE, start_ready=1.
- PIU_SCAN_ABORT_EN: M scan, abort after 2 beats -> out_valid drops, scan_done pulses next cycle, match_cnt=2.
